// File: rtl/bbox_tracker_pkg.sv
// Shared types and widths for the bounding-box tracker and the sprite overlays it feeds.
package bbox_tracker_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;

  // Raster counter widths and sprite-ready coordinate widths
  localparam int HC_W = 11;
  localparam int VC_W = 10;
  localparam int X_W  = 12;
  localparam int Y_W  = 11;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] xmax;
    logic [Y_W-1:0] ymax;
    logic           valid;
  } bbox_t;

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH, PUBLISH} bbox_state_t;

endpackage

// File: rtl/bbox_tracker_if.sv
// Pixel-stream input and published-box output bundle of the tracker.
interface bbox_tracker_if;
  import bbox_tracker_pkg::*;

  logic [HC_W-1:0] hcount_in;
  logic [VC_W-1:0] vcount_in;
  logic            valid_in;
  logic            mask_in;
  logic            new_frame_in;
  logic [X_W-1:0]  x_out;
  logic [Y_W-1:0]  y_out;
  logic [X_W-1:0]  xmax_out;
  logic [Y_W-1:0]  ymax_out;
  logic            box_valid_out;
  logic            done_out;

  // Tracker side
  modport slave (
    input  hcount_in, vcount_in, valid_in, mask_in, new_frame_in,
    output x_out, y_out, xmax_out, ymax_out, box_valid_out, done_out
  );

  // Mask-stage / consumer side
  modport master (
    output hcount_in, vcount_in, valid_in, mask_in, new_frame_in,
    input  x_out, y_out, xmax_out, ymax_out, box_valid_out, done_out
  );

endinterface

// File: rtl/bbox_tracker_minmax_accum.sv
// Per-axis running min/max of qualifying pixel coordinates.
// clr restarts the pair for a new frame and still folds in that cycle's pixel.
module minmax_accum #(
  parameter int W = 11
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] min_q,
  output logic [W-1:0] max_q
);

  // Min starts at all-ones and max at zero so the first loaded pixel wins both
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clr) begin
      min_q <= load ? din : '1;
      max_q <= load ? din : '0;
    end else if (load) begin
      if (din < min_q) min_q <= din;
      if (din > max_q) max_q <= din;
    end
  end

endmodule

// File: rtl/bbox_tracker.sv
// Per-frame bounding-box extractor: tracks min/max of set mask pixels and publishes
// centre and far edges two cycles after each frame boundary.
module bbox_tracker
  import bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 20
) (
  input  logic           clk_in,
  input  logic           rst_in,
  bbox_tracker_if.slave  bus
);

  logic            qual;
  logic [HC_W-1:0] xmin, xmax;
  logic [VC_W-1:0] ymin, ymax;
  logic [CNT_W-1:0] count;
  logic            cnt_ok;

  bbox_state_t     state, state_nx;
  logic            snap_en, pub_en;

  logic [HC_W-1:0] snap_xmin, snap_xmax;
  logic [VC_W-1:0] snap_ymin, snap_ymax;
  logic            snap_ok;

  logic [X_W:0]    sum_x;
  logic [Y_W:0]    sum_y;
  bbox_t           box_nx, res_q;
  logic            done_q;

  assign qual = bus.valid_in & bus.mask_in
              & (bus.hcount_in < HC_W'(H_ACTIVE))
              & (bus.vcount_in < VC_W'(V_ACTIVE));

  minmax_accum #(.W(HC_W)) u_x_accum (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (bus.new_frame_in),
    .load   (qual),
    .din    (bus.hcount_in),
    .min_q  (xmin),
    .max_q  (xmax)
  );

  minmax_accum #(.W(VC_W)) u_y_accum (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (bus.new_frame_in),
    .load   (qual),
    .din    (bus.vcount_in),
    .min_q  (ymin),
    .max_q  (ymax)
  );

  // Saturating set-pixel counter; the new_frame_in pixel belongs to the new frame
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (bus.new_frame_in) begin
      count <= {{(CNT_W-1){1'b0}}, qual};
    end else if (qual && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // A zero count is never a box, even if MIN_PIXELS is configured as 0
  assign cnt_ok = (count >= CNT_W'(MIN_PIXELS)) && (count != '0);

  // Result FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; frame ends seen during LATCH/PUBLISH are not snapshotted
  always_comb begin
    state_nx = state;
    snap_en  = 1'b0;
    pub_en   = 1'b0;
    case (state)
      IDLE:    if (bus.new_frame_in) state_nx = ACCUM;
      ACCUM:   if (bus.new_frame_in) begin
                 state_nx = LATCH;
                 snap_en  = 1'b1;
               end
      LATCH:   begin
                 state_nx = PUBLISH;
                 pub_en   = 1'b1;
               end
      PUBLISH: state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  // Snapshot of the ended frame, taken before the accumulators restart
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      snap_ok   <= 1'b0;
    end else if (snap_en) begin
      snap_xmin <= xmin;
      snap_xmax <= xmax;
      snap_ymin <= ymin;
      snap_ymax <= ymax;
      snap_ok   <= cnt_ok;
    end
  end

  // Centre = floor of the min/max midpoint; an undersized frame publishes an all-zero box
  always_comb begin
    sum_x  = (X_W+1)'(snap_xmin) + (X_W+1)'(snap_xmax);
    sum_y  = (Y_W+1)'(snap_ymin) + (Y_W+1)'(snap_ymax);
    box_nx = '0;
    if (snap_ok) begin
      box_nx.x     = sum_x[X_W:1];
      box_nx.y     = sum_y[Y_W:1];
      box_nx.xmax  = X_W'(snap_xmax);
      box_nx.ymax  = Y_W'(snap_ymax);
      box_nx.valid = 1'b1;
    end
  end

  // Output registers, written once per publish and held otherwise
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= pub_en;
      if (pub_en) res_q <= box_nx;
    end
  end

  assign bus.x_out         = res_q.x;
  assign bus.y_out         = res_q.y;
  assign bus.xmax_out      = res_q.xmax;
  assign bus.ymax_out      = res_q.ymax;
  assign bus.box_valid_out = res_q.valid;
  assign bus.done_out      = done_q;

endmodule

// File: tb/tb_bbox_tracker.sv
// Scoreboard bench for bbox_tracker: a frame-level reference model queues expected
// publishes; a monitor checks each done_out pulse and that outputs hold in between.
module tb_bbox_tracker;

  localparam int H_ACT = 1280;
  localparam int V_ACT = 720;
  localparam int MINP  = 16;

  typedef struct {
    longint t;
    int     x, y, xmax, ymax;
    bit     v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bbox_tracker_if bus ();

  bbox_tracker #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .MIN_PIXELS(MINP), .CNT_W(20)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int     nchk  = 0;
  int     npass = 0;
  exp_t   sb[$];
  int     fh[$];
  int     fv[$];
  bit     armed = 1'b0;
  longint last_acc = -1000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [46:0] pack(input int x, input int y, input int xm, input int ym, input bit v);
    return {12'(x), 11'(y), 12'(xm), 11'(ym), v};
  endfunction

  function automatic logic [46:0] dut_pack();
    return {bus.x_out, bus.y_out, bus.xmax_out, bus.ymax_out, bus.box_valid_out};
  endfunction

  // Box of the collected frame: plain min/max over the set-pixel list
  function automatic exp_t frame_result(input longint t);
    exp_t e;
    int xmn, xmx, ymn, ymx;
    e.t = t; e.x = 0; e.y = 0; e.xmax = 0; e.ymax = 0; e.v = 1'b0;
    if (fh.size() >= MINP && fh.size() > 0) begin
      xmn = fh[0]; xmx = fh[0]; ymn = fv[0]; ymx = fv[0];
      foreach (fh[i]) begin
        if (fh[i] < xmn) xmn = fh[i];
        if (fh[i] > xmx) xmx = fh[i];
        if (fv[i] < ymn) ymn = fv[i];
        if (fv[i] > ymx) ymx = fv[i];
      end
      e.x = (xmn + xmx) / 2; e.y = (ymn + ymx) / 2;
      e.xmax = xmx; e.ymax = ymx; e.v = 1'b1;
    end
    return e;
  endfunction

  // Reference behaviour for one pixel captured at clock edge e_t.
  // A frame end is published only if the previous publish started at least 3 cycles earlier.
  task automatic model_step(input int h, input int v, input bit vld, input bit m, input bit nf, input longint e_t);
    if (nf) begin
      if (!armed) begin
        armed = 1'b1;
        last_acc = -1000;
      end else if (e_t - last_acc >= 30) begin
        sb.push_back(frame_result(e_t + 15));
        last_acc = e_t;
      end
      fh.delete();
      fv.delete();
    end
    if (vld && m && h < H_ACT && v < V_ACT) begin
      fh.push_back(h);
      fv.push_back(v);
    end
  endtask

  task automatic drive(input int h, input int v, input bit vld, input bit m, input bit nf);
    @(posedge clk);
    #1;
    bus.hcount_in    = 11'(h);
    bus.vcount_in    = 10'(v);
    bus.valid_in     = vld;
    bus.mask_in      = m;
    bus.new_frame_in = nf;
    model_step(h, v, vld, m, nf, $time + 9);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.new_frame_in = 1'b0;
    #1;
    chk("async_reset_outputs", dut_pack(), 47'd0);
    chk("async_reset_done", bus.done_out, 1'b0);
    sb.delete();
    fh.delete();
    fv.delete();
    armed = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every negedge either a publish (popped from the scoreboard) or held outputs
  initial begin
    exp_t e;
    logic [46:0] cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '0;
      end else begin
        while (sb.size() > 0 && sb[0].t < $time) begin
          nchk++;
          $display("FAIL done_missing: no done_out by %0t, required at %0t", $time, sb[0].t);
          void'(sb.pop_front());
        end
        if (bus.done_out) begin
          if (sb.size() == 0) begin
            nchk++;
            $display("FAIL spurious_done: done_out=1 at %0t, required none", $time);
          end else begin
            e = sb.pop_front();
            chk("done_time", $time, e.t);
            chk("box_result", dut_pack(), pack(e.x, e.y, e.xmax, e.ymax, e.v));
            cur = pack(e.x, e.y, e.xmax, e.ymax, e.v);
          end
        end else begin
          chk("hold", dut_pack(), cur);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    bus.hcount_in = '0; bus.vcount_in = '0;
    bus.valid_in = 1'b0; bus.mask_in = 1'b0; bus.new_frame_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", dut_pack(), 47'd0);
    chk("reset_done", bus.done_out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Partial frame before the first boundary is discarded
    for (int i = 0; i < 20; i++) drive(400 + i, 300, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);

    // 10x10 square with unqualified noise
    for (int r = 50; r < 60; r++) begin
      for (int c = 100; c < 110; c++) drive(c, r, 1'b1, 1'b1, 1'b0);
      drive(900, 600, 1'b1, 1'b0, 1'b0);
      drive(5, 700, 1'b0, 1'b1, 1'b0);
    end
    drive(0, 0, 1'b0, 1'b0, 1'b1);

    // Sparse: 15 set pixels, below threshold
    for (int i = 0; i < 15; i++) drive(10 + i, 20, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);

    // Active-area boundary: 1280 and row 720 ignored
    drive(1279, 0, 1'b1, 1'b1, 1'b0);
    drive(1280, 0, 1'b1, 1'b1, 1'b0);
    drive(600, 720, 1'b1, 1'b1, 1'b0);
    drive(2047, 1023, 1'b1, 1'b1, 1'b0);
    drive(700, 719, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) drive(600 + i, 300, 1'b1, 1'b1, 1'b0);

    // Pixel on the boundary cycle belongs to the next frame
    drive(5, 5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) drive(50 + i, 30, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);

    // Back-to-back boundary: the one-cycle frame is dropped
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) drive(800 + i, 400 + i, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);

    // valid_in low for a whole frame
    for (int i = 0; i < 20; i++) drive(300 + i, 200, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Randomized frames, including short gaps between boundaries
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 60);
      for (int i = 0; i < n; i++)
        drive($urandom_range(0, 1300), $urandom_range(0, 740),
              $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'b0);
      drive($urandom_range(0, 1300), $urandom_range(0, 740),
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b1);
    end
    idle(4);

    // Reset mid-frame, then two boundaries are needed before a publish
    for (int i = 0; i < 10; i++) drive(100 + i, 100, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(120 + i, 110, 1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) drive(200 + i, 150, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(220 + i, 160 + i, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    idle(10);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
